// File: rtl/wb_arb_pkg.sv
// Shared Wishbone arbiter definitions: cycle/burst type encodings and width helpers.
package wb_arb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Index width that never collapses to zero for a single-entry vector.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = clog2_min1(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  always_comb begin
    int unsigned base;
    int unsigned cand;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    base  = 32'(last_i) + 32'd1;
    // Walk offsets 0..NumReq-1 from last_i+1; candidate index stays below 2*NumReq.
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = base + off;
      if (cand >= NumReq) cand = cand - NumReq;
      if (cand >= NumReq) cand = cand - NumReq;
      for (int unsigned j = 0; j < NumReq; j++) begin
        if (!found && req_i[j] && (j == cand)) begin
          found    = 1'b1;
          gnt_o[j] = 1'b1;
          idx_o    = IdxW'(j);
        end
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone B3 arbiter with registered round-robin grant and
// an access watchdog that terminates stalled accesses with err.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 32,
  parameter int unsigned TIMEOUT     = 255,
  localparam int unsigned SELW       = DW / 8
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*SELW-1:0] m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [SELW-1:0]             s_sel_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int unsigned IdxW = clog2_min1(NUM_MASTERS);
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [NUM_MASTERS-1:0] grant_q, grant_d, pick_gnt;
  logic [IdxW-1:0]        last_q, last_d, pick_idx;
  logic                   pick_valid;
  logic                   owner_cyc;
  logic                   mux_stb;
  logic                   slv_resp;
  logic                   fire;

  wb_rr_pick #(
    .NumReq (NUM_MASTERS),
    .IdxW   (IdxW)
  ) u_pick (
    .req_i   (m_cyc_i),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Re-arbitrate whenever there is no owner or the owner has released cyc.
  assign owner_cyc = |(grant_q & m_cyc_i);

  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    if (!owner_cyc) begin
      grant_d = pick_gnt;
      if (pick_valid) last_d = pick_idx;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      grant_q <= '0;
      last_q  <= IdxW'(NUM_MASTERS - 1);
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // One-hot AND-OR mux; an idle grant drives every slave field to zero.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    s_cyc_o = 1'b0;
    mux_stb = 1'b0;
    s_we_o  = 1'b0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      s_adr_o |= m_adr_i[k*AW +: AW]     & {AW{grant_q[k]}};
      s_dat_o |= m_dat_i[k*DW +: DW]     & {DW{grant_q[k]}};
      s_sel_o |= m_sel_i[k*SELW +: SELW] & {SELW{grant_q[k]}};
      s_cti_o |= m_cti_i[k*3 +: 3]       & {3{grant_q[k]}};
      s_bte_o |= m_bte_i[k*2 +: 2]       & {2{grant_q[k]}};
      s_cyc_o |= m_cyc_i[k] & grant_q[k];
      mux_stb |= m_stb_i[k] & grant_q[k];
      s_we_o  |= m_we_i[k]  & grant_q[k];
    end
  end

  assign slv_resp = s_ack_i | s_err_i | s_rty_i;

  if (TIMEOUT > 0) begin : g_wdog
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stall;

    assign stall = s_cyc_o & mux_stb & ~slv_resp;
    // Fires on the cycle the count would reach TIMEOUT; a real response that cycle wins.
    assign fire  = stall & (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
      cnt_d = '0;
      if (stall && !fire) cnt_d = cnt_q + CntW'(1);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) cnt_q <= '0;
      else             cnt_q <= cnt_d;
    end
  end else begin : g_no_wdog
    assign fire = 1'b0;
  end

  assign s_stb_o   = mux_stb & ~fire;
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = grant_q & {NUM_MASTERS{s_ack_i}};
  assign m_err_o   = grant_q & {NUM_MASTERS{s_err_i | fire}};
  assign m_rty_o   = grant_q & {NUM_MASTERS{s_rty_i}};
  assign grant_o   = grant_q;
  assign timeout_o = fire;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: per-cycle model comparison plus directed literal checks.
module tb_wb_rr_arbiter;

  localparam int unsigned N    = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned SELW = DW / 8;
  localparam int unsigned TO   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N*AW-1:0]   m_adr = '0;
  logic [N*DW-1:0]   m_dat = '0;
  logic [N*SELW-1:0] m_sel = '0;
  logic [N*3-1:0]    m_cti = '0;
  logic [N*2-1:0]    m_bte = '0;
  logic [N-1:0]      m_cyc = '0;
  logic [N-1:0]      m_stb = '0;
  logic [N-1:0]      m_we = '0;
  logic [DW-1:0]     s_dat = '0;
  logic              s_ack = 1'b0;
  logic              s_err = 1'b0;
  logic              s_rty = 1'b0;

  logic [DW-1:0]     m_dat_o;
  logic [N-1:0]      m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [SELW-1:0]   s_sel_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic              s_cyc_o, s_stb_o, s_we_o, timeout_o;

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .NUM_MASTERS (N),
    .DW          (DW),
    .AW          (AW),
    .TIMEOUT     (TO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .m_adr_i    (m_adr),
    .m_dat_i    (m_dat),
    .m_sel_i    (m_sel),
    .m_cti_i    (m_cti),
    .m_bte_i    (m_bte),
    .m_cyc_i    (m_cyc),
    .m_stb_i    (m_stb),
    .m_we_i     (m_we),
    .m_dat_o    (m_dat_o),
    .m_ack_o    (m_ack_o),
    .m_err_o    (m_err_o),
    .m_rty_o    (m_rty_o),
    .s_adr_o    (s_adr_o),
    .s_dat_o    (s_dat_o),
    .s_sel_o    (s_sel_o),
    .s_cti_o    (s_cti_o),
    .s_bte_o    (s_bte_o),
    .s_cyc_o    (s_cyc_o),
    .s_stb_o    (s_stb_o),
    .s_we_o     (s_we_o),
    .s_dat_i    (s_dat),
    .s_ack_i    (s_ack),
    .s_err_i    (s_err),
    .s_rty_i    (s_rty),
    .grant_o    (grant_o),
    .timeout_o  (timeout_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: owner index (-1 = idle), last winner, stalled-cycle count.
  int owner = -1;
  int last  = N - 1;
  int stall = 0;

  function automatic bit model_stall();
    if (owner < 0) return 1'b0;
    return m_cyc[owner] && m_stb[owner] && !s_ack && !s_err && !s_rty;
  endfunction

  function automatic bit model_fire();
    return model_stall() && (stall == TO - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= -1;
      last  <= N - 1;
      stall <= 0;
    end else begin : upd
      int no;
      int nl;
      int k;
      no = owner;
      nl = last;
      if (owner < 0 || !m_cyc[owner]) begin
        no = -1;
        for (int i = 1; i <= N; i++) begin
          k = (last + i) % N;
          if (no < 0 && m_cyc[k]) begin
            no = k;
            nl = k;
          end
        end
      end
      stall <= (model_stall() && !model_fire()) ? stall + 1 : 0;
      owner <= no;
      last  <= nl;
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin : cmp
      logic [N-1:0]  eg;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [SELW-1:0] es;
      logic [2:0]    ec;
      logic [1:0]    eb;
      bit            oc, os, ow, ef;
      eg = '0; ea = '0; ed = '0; es = '0; ec = '0; eb = '0;
      oc = 0; os = 0; ow = 0;
      if (owner >= 0) begin
        eg = N'(1) << owner;
        ea = m_adr[owner*AW +: AW];
        ed = m_dat[owner*DW +: DW];
        es = m_sel[owner*SELW +: SELW];
        ec = m_cti[owner*3 +: 3];
        eb = m_bte[owner*2 +: 2];
        oc = m_cyc[owner];
        os = m_stb[owner];
        ow = m_we[owner];
      end
      ef = model_fire();
      check("grant", grant_o, eg);
      check("s_cyc", s_cyc_o, oc);
      check("s_stb", s_stb_o, os && !ef);
      check("s_we", s_we_o, ow);
      check("s_adr", s_adr_o, ea);
      check("s_dat", s_dat_o, ed);
      check("s_sel", s_sel_o, es);
      check("s_cti", s_cti_o, ec);
      check("s_bte", s_bte_o, eb);
      check("m_ack", m_ack_o, s_ack ? eg : '0);
      check("m_err", m_err_o, (s_err || ef) ? eg : '0);
      check("m_rty", m_rty_o, s_rty ? eg : '0);
      check("timeout", timeout_o, ef);
      check("m_dat", m_dat_o, s_dat);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int k, input bit c, input bit s);
    m_cyc[k] = c;
    m_stb[k] = s;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; s_ack = 0; s_err = 0; s_rty = 0;
    #10;
    rst_n = 1'b1;
  endtask

  initial begin #200000; $display("FAIL global_timeout: simulation did not finish"); $fatal(1); end

  initial begin
    logic [N-1:0] order [5];
    int prev;
    int o;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
    order[3] = 3'b001; order[4] = 3'b010;
    for (int k = 0; k < N; k++) begin
      m_dat[k*DW +: DW]     = 32'hA000_0000 + 32'(k);
      m_sel[k*SELW +: SELW] = SELW'(k + 1);
      m_bte[k*2 +: 2]       = 2'(k);
    end
    m_we[2] = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    run_chk = 1'b1;

    // Single master 1 classic read
    next();
    m_adr[1*AW +: AW] = 32'h100;
    set_m(1, 1, 1);
    @(negedge clk); check("t1_request_idle_grant", grant_o, 3'b000);
    next();
    @(negedge clk); check("t1_grant", grant_o, 3'b010);
    check("t1_s_adr", s_adr_o, 32'h100);
    next();
    s_ack = 1; s_dat = 32'hDEADBEEF;
    @(negedge clk); check("t1_ack", m_ack_o, 3'b010);
    check("t1_rdata", m_dat_o, 32'hDEADBEEF);
    next();
    s_ack = 0; set_m(1, 0, 0);
    next(); next();

    // Tie between masters 0 and 2 after reset
    do_reset();
    next();
    set_m(0, 1, 1); set_m(2, 1, 1);
    next();
    s_ack = 1;
    @(negedge clk); check("t2_first_grant", grant_o, 3'b001);
    check("t2_ack_gated", m_ack_o, 3'b001);
    next();
    s_ack = 0; set_m(0, 0, 0);
    next();
    @(negedge clk); check("t2_handover", grant_o, 3'b100);
    s_ack = 1;
    next();
    s_ack = 0; set_m(2, 0, 0);
    next(); next();

    // Continuous three-way contention, one access each
    do_reset();
    next();
    set_m(0, 1, 1); set_m(1, 1, 1); set_m(2, 1, 1);
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      next();
      if (prev >= 0) set_m(prev, 1, 1);
      s_ack = 1;
      @(negedge clk); check("t3_rr_order", grant_o, order[i]);
      o = (order[i] == 3'b001) ? 0 : (order[i] == 3'b010) ? 1 : 2;
      next();
      s_ack = 0; set_m(o, 0, 0);
      prev = o;
    end
    next();
    m_cyc = '0; m_stb = '0;
    next(); next();

    // Master 0 burst with master 1 waiting
    do_reset();
    next();
    m_cti[0 +: 3] = CTI_INC_TB();
    m_adr[0 +: AW] = 32'h200;
    set_m(0, 1, 1); set_m(1, 1, 1);
    next();
    for (int b = 0; b < 4; b++) begin
      m_adr[0 +: AW] = 32'h200 + 32'(4 * b);
      m_cti[0 +: 3] = (b == 3) ? 3'b111 : 3'b010;
      s_ack = 1;
      @(negedge clk); check("t4_burst_grant", grant_o, 3'b001);
      check("t4_burst_ack", m_ack_o, 3'b001);
      next();
    end
    s_ack = 0; set_m(0, 0, 0); m_cti[0 +: 3] = 3'b000;
    next();
    @(negedge clk); check("t4_after_burst", grant_o, 3'b010);
    s_ack = 1;
    next();
    s_ack = 0; set_m(1, 0, 0);
    next(); next();

    // Watchdog fires on the 8th stalled cycle
    do_reset();
    next();
    set_m(2, 1, 1);
    next();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("t5_timeout_pulse", timeout_o, (c == 8));
      check("t5_stb_withdrawn", s_stb_o, (c != 8));
      if (c == 8) check("t5_err_owner", m_err_o, 3'b100);
      next();
    end
    @(negedge clk); check("t5_pulse_one_cycle", timeout_o, 1'b0);
    next();
    set_m(2, 0, 0);
    next(); next();

    // Slave ack on the 8th stalled cycle beats the watchdog
    do_reset();
    next();
    set_m(2, 1, 1);
    next();
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) s_ack = 1;
      @(negedge clk);
      if (c == 8) begin
        check("t5b_ack_wins", m_ack_o, 3'b100);
        check("t5b_no_err", m_err_o, 3'b000);
        check("t5b_no_timeout", timeout_o, 1'b0);
      end
      next();
    end
    s_ack = 0; set_m(2, 0, 0);
    next(); next();

    // Asynchronous reset mid-burst
    do_reset();
    next();
    m_cti[0 +: 3] = 3'b010;
    set_m(0, 1, 1); set_m(1, 1, 1); set_m(2, 1, 1);
    next();
    s_ack = 1;
    @(negedge clk); check("t6_pre_reset_grant", grant_o, 3'b001);
    next();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_grant", grant_o, 3'b000);
    check("t6_rst_cyc", s_cyc_o, 1'b0);
    check("t6_rst_stb", s_stb_o, 1'b0);
    check("t6_rst_ack", m_ack_o, 3'b000);
    @(posedge clk);
    #3;
    s_ack = 0;
    rst_n = 1'b1;
    next();
    @(negedge clk); check("t6_tie_after_reset", grant_o, 3'b001);
    next();
    m_cyc = '0; m_stb = '0; m_cti = '0;
    next(); next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [2:0] CTI_INC_TB();
    return 3'b010;
  endfunction

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Parametrised N-master to 1-slave Wishbone B3 arbiter with a registered round-robin grant. Generalises the fixed 3-master RAM front end.
- Sits in front of any single Wishbone slave (RAM, peripheral bridge), so the arbiter and the slave are separate instances.
- Adds two things the 3-master front end lacks: fair round-robin ordering for any master count, and a per-access watchdog that terminates hung accesses with err.

Parameters:
NUM_MASTERS, 3, number of master ports (1..16)
DW, 32, data width (multiple of 8)
AW, 32, address width
TIMEOUT, 255, cycles stb may wait for ack/err/rty before forced err; 0 disables watchdog
SELW, DW/8, byte-select width (derived, not overridden)

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  asynchronous active-low reset
m_adr_i  in  NUM_MASTERS*AW  master addresses, master k at [k*AW +: AW] (same packing for all m_* vectors)
m_dat_i  in  NUM_MASTERS*DW  master write data
m_sel_i  in  NUM_MASTERS*SELW  byte selects
m_cti_i  in  NUM_MASTERS*3  cycle type
m_bte_i  in  NUM_MASTERS*2  burst type
m_cyc_i  in  NUM_MASTERS  cycle
m_stb_i  in  NUM_MASTERS  strobe
m_we_i  in  NUM_MASTERS  write enable
m_dat_o  out  DW  read data, broadcast to all masters
m_ack_o  out  NUM_MASTERS  ack, gated by grant
m_err_o  out  NUM_MASTERS  err, gated by grant, includes watchdog err
m_rty_o  out  NUM_MASTERS  rty, gated by grant
s_adr_o  out  AW  to slave
s_dat_o  out  DW  to slave
s_sel_o  out  SELW  to slave
s_cti_o  out  3  to slave
s_bte_o  out  2  to slave
s_cyc_o  out  1  to slave
s_stb_o  out  1  to slave
s_we_o  out  1  to slave
s_dat_i  in  DW  from slave
s_ack_i  in  1  from slave
s_err_i  in  1  from slave
s_rty_i  in  1  from slave
grant_o  out  NUM_MASTERS  one-hot current owner, all-zero when idle
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset values: grant register = 0 and last_owner = NUM_MASTERS-1, so master 0 wins the first tie. Watchdog count = 0. All s_* outputs = 0. All m_ack/err/rty = 0. timeout_o = 0. m_dat_o follows s_dat_i.
- Arbitration runs at the clock edge when no master is granted, or when the granted master's m_cyc_i is low. That edge loads the winner, so handover costs zero idle cycles.
- Winner: the first master with cyc high, searching from last_owner+1 upward with wrap modulo NUM_MASTERS. last_owner updates on every new grant.
- If no master requests, grant goes to 0.
- The grant is held for as long as the owner keeps cyc high. This covers bursts (cti 001/010) and RMW sequences, and the owner is never pre-empted.
- Slave mux: when granted, s_* = the owner's fields. When grant = 0, s_* = 0, so s_cyc_o and s_stb_o are low.
- The cycle cyc rises at an idle arbiter is the request cycle. The grant appears one cycle later, and s_cyc_o asserts in the same cycle as the grant. The minimum access latency added is 1 cycle.
- Responses: m_ack_o[k] = s_ack_i & grant[k]. err and rty are gated the same way. A master without grant never sees a response.
- Watchdog (TIMEOUT>0):
  - The counter increments each cycle that s_cyc_o & s_stb_o are high and s_ack_i, s_err_i and s_rty_i are all low.
  - It clears on any slave response or when stb drops.
  - When the count reaches TIMEOUT, the arbiter drives m_err_o[owner] = 1 and timeout_o = 1 for exactly one cycle and clears the counter.
  - In that same cycle s_stb_o is forced low, so the slave sees the access withdrawn.
  - If a slave response arrives in the same cycle the count reaches TIMEOUT, the slave response wins and the watchdog does not fire.
- TIMEOUT = 0: the counter logic is removed and timeout_o is tied to 0.
- Owner drops cyc mid-burst: the grant moves at the next edge, and the slave sees cyc fall through the mux.
- Reset asserted mid-access: all outputs go to reset values immediately (asynchronously). No response is delivered.
- NUM_MASTERS = 1: the grant reduces to a registered copy of m_cyc_i[0], with the same 1-cycle latency.
- Counter width is $clog2(TIMEOUT+1). Index width is $clog2(NUM_MASTERS), minimum 1.

Decomposition:
- Package wb_arb_pkg:
  - CTI/BTE localparams: CTI_CLASSIC = 3'b000, CTI_CONST = 3'b001, CTI_INC = 3'b010, CTI_EOB = 3'b111, BTE_LINEAR = 2'b00.
  - Function clog2_min1.
- Sub-module wb_rr_pick: a combinational round-robin picker (request vector + last_owner in, one-hot and index out).
- wb_rr_arbiter holds the grant and last_owner registers, the muxes and the watchdog.

Test Plan:
- Single master 1 issues a classic read to 0x100, slave acks after 2 cycles with 0xDEADBEEF:
  - grant_o = 3'b010 one cycle after cyc.
  - m_ack_o = 3'b010 with m_dat_o = 0xDEADBEEF.
  - m_ack_o[0] and m_ack_o[2] stay 0.
- After reset, masters 0 and 2 raise cyc in the same cycle:
  - Master 0 is granted first.
  - When master 0 drops cyc, grant_o becomes 3'b100 at the very next edge.
- All three masters hold cyc continuously and each releases after one access: grant order is 0, 1, 2, 0, 1.
- Master 0 runs a 4-beat incrementing burst (cti 010, 010, 010, 111) while master 1 requests: grant_o stays 3'b001 for all 4 acks and then moves to 3'b010.
- TIMEOUT = 8 and the slave never responds:
  - On the 8th stalled cycle, m_err_o[owner] = 1 and timeout_o = 1 for one cycle, with s_stb_o low in that cycle.
  - In a second run where s_ack_i arrives on the 8th stalled cycle, only the ack is delivered.
- wb_rst_n_i is pulled low mid-burst:
  - grant_o, s_cyc_o, s_stb_o and all m_ack_o go to 0 without waiting for a clock edge.
  - After release, master 0 again wins a three-way tie.
